// File: rtl/sseg_pkg.sv
// Shared constants and the hex glyph decoder for the seven-segment scan driver.
package sseg_pkg;

   localparam int unsigned BRIGHT_W = 4;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Active-high {a, b, c, d, e, f, g}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      logic [6:0] seg;
      unique case (hex)
         4'h0: seg = 7'h7E;
         4'h1: seg = 7'h30;
         4'h2: seg = 7'h6D;
         4'h3: seg = 7'h79;
         4'h4: seg = 7'h33;
         4'h5: seg = 7'h5B;
         4'h6: seg = 7'h5F;
         4'h7: seg = 7'h70;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h7B;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h1F;
         4'hC: seg = 7'h4E;
         4'hD: seg = 7'h3D;
         4'hE: seg = 7'h4F;
         4'hF: seg = 7'h47;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/sseg_lz_mask.sv
// Leading-zero blank mask: a digit is masked when it is zero and every higher
// digit is zero or disabled. Digit 0 is never masked.
module sseg_lz_mask #(
   parameter int unsigned DIGITS = 3
) (
   input  logic [4*DIGITS-1:0] hex_i,
   input  logic [DIGITS-1:0]   en_i,
   output logic [DIGITS-1:0]   mask_o
);

   always_comb begin
      mask_o = '0;
      for (int i = 1; i < DIGITS; i++) begin
         mask_o[i] = (hex_i[4*i +: 4] == 4'd0);
         for (int j = i + 1; j < DIGITS; j++) begin
            if ((hex_i[4*j +: 4] != 4'd0) && en_i[j]) mask_o[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed seven-segment driver with frame-atomic shadow loading,
// blink, PWM brightness and leading-zero blanking.
module sseg_scan_mux
   import sseg_pkg::*;
#(
   parameter int unsigned DIGITS     = 3,
   parameter int unsigned SCAN_LOG2  = 12,
   parameter int unsigned BLINK_LOG2 = 6,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   hex_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     en_in,
   input  logic [DIGITS-1:0]     blink_in,
   input  logic [BRIGHT_W-1:0]   bright_in,
   input  logic                  lz_blank,
   output logic [DIGITS-1:0]     an,
   output logic [7:0]            sseg,
   output logic                  frame_tick,
   output logic                  busy
);

   localparam int unsigned IdxW = $clog2(DIGITS);

   typedef struct packed {
      logic [4*DIGITS-1:0] hex;
      logic [DIGITS-1:0]   dp;
      logic [DIGITS-1:0]   en;
      logic [DIGITS-1:0]   blink;
      logic [BRIGHT_W-1:0] bright;
      logic                lz;
   } disp_t;

   logic [SCAN_LOG2-1:0]  slot_q, slot_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [BLINK_LOG2-1:0] blink_cnt_q, blink_cnt_d;
   logic                  blink_ph_q, blink_ph_d;
   disp_t                 act_q, act_d, pend_q, pend_d, in_data;
   logic                  busy_q, busy_d;
   logic [DIGITS-1:0]     an_q, an_d, an_raw, lz_mask;
   logic [7:0]            sseg_q, sseg_d, seg_raw;
   logic                  tick_q;
   logic                  slot_wrap, last_idx, frame_wrap, blank, pwm_on;
   logic [3:0]            cur_val;

   sseg_lz_mask #(
      .DIGITS(DIGITS)
   ) u_lz_mask (
      .hex_i (act_q.hex),
      .en_i  (act_q.en),
      .mask_o(lz_mask)
   );

   assign in_data    = '{hex: hex_in, dp: dp_in, en: en_in, blink: blink_in,
                         bright: bright_in, lz: lz_blank};
   assign slot_wrap  = &slot_q;
   assign last_idx   = (idx_q == IdxW'(DIGITS - 1));
   assign frame_wrap = slot_wrap & last_idx;

   always_comb begin
      slot_d      = slot_q + 1'b1;
      idx_d       = idx_q;
      blink_cnt_d = blink_cnt_q;
      blink_ph_d  = blink_ph_q;
      act_d       = act_q;
      pend_d      = pend_q;
      busy_d      = busy_q;
      if (slot_wrap) idx_d = last_idx ? '0 : idx_q + 1'b1;
      if (frame_wrap) begin
         blink_cnt_d = blink_cnt_q + 1'b1;
         if (&blink_cnt_q) blink_ph_d = ~blink_ph_q;
      end
      // A load landing on the wrap bypasses the pending copy entirely.
      if (frame_wrap && load) begin
         act_d  = in_data;
         busy_d = 1'b0;
      end else if (frame_wrap && busy_q) begin
         act_d  = pend_q;
         busy_d = 1'b0;
      end else if (load) begin
         pend_d = in_data;
         busy_d = 1'b1;
      end
   end

   always_comb begin
      cur_val = act_q.hex[{idx_q, 2'b00} +: 4];
      blank   = ~act_q.en[idx_q] | (act_q.lz & lz_mask[idx_q]) |
                (act_q.blink[idx_q] & blink_ph_q);
      pwm_on  = slot_q[SCAN_LOG2-1 -: BRIGHT_W] < act_q.bright;
      an_raw  = (!blank && pwm_on) ? (DIGITS'(1) << idx_q) : '0;
      seg_raw = blank ? {1'b0, SEG_BLANK} : {act_q.dp[idx_q], hex_to_seg(cur_val)};
      an_d    = ACTIVE_LOW ? ~an_raw : an_raw;
      sseg_d  = ACTIVE_LOW ? ~seg_raw : seg_raw;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q      <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         act_q       <= '0;
         pend_q      <= '0;
         busy_q      <= 1'b0;
         an_q        <= {DIGITS{ACTIVE_LOW}};
         sseg_q      <= {8{ACTIVE_LOW}};
         tick_q      <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         idx_q       <= idx_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         act_q       <= act_d;
         pend_q      <= pend_d;
         busy_q      <= busy_d;
         an_q        <= an_d;
         sseg_q      <= sseg_d;
         tick_q      <= frame_wrap;
      end
   end

   assign an         = an_q;
   assign sseg       = sseg_q;
   assign frame_tick = tick_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Randomised bench for sseg_scan_mux against a frame-arithmetic reference model.
module tb_sseg_scan_mux;

   localparam int DIGITS     = 3;
   localparam int SCAN_LOG2  = 4;
   localparam int BLINK_LOG2 = 1;
   localparam int SLOT       = 1 << SCAN_LOG2;
   localparam int FRAME      = DIGITS * SLOT;

   localparam logic [6:0] GLYPH [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F,
      7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   typedef struct {
      int          e;
      logic [11:0] hex;
      logic [2:0]  dp;
      logic [2:0]  en;
      logic [2:0]  blink;
      logic [3:0]  bright;
      logic        lz;
   } ld_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [11:0] hex_in = '0;
   logic [2:0]  dp_in = '0, en_in = '0, blink_in = '0;
   logic [3:0]  bright_in = '0;
   logic        lz_blank = 1'b0;
   logic [2:0]  an;
   logic [7:0]  sseg;
   logic        frame_tick, busy;
   logic [12:0] obs;

   int  k = 0;
   int  tests_run = 0;
   int  failures = 0;
   ld_t q[$];

   sseg_scan_mux #(
      .DIGITS(DIGITS), .SCAN_LOG2(SCAN_LOG2), .BLINK_LOG2(BLINK_LOG2), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .load(load), .hex_in(hex_in), .dp_in(dp_in), .en_in(en_in),
      .blink_in(blink_in), .bright_in(bright_in), .lz_blank(lz_blank), .an(an), .sseg(sseg),
      .frame_tick(frame_tick), .busy(busy)
   );

   assign obs = {an, sseg, frame_tick, busy};

   always #5 clk = ~clk;

   // k = clock edges since reset release; the scan position is pure arithmetic on k.
   always @(posedge clk or posedge reset) begin
      if (reset) k <= 0;
      else k <= k + 1;
   end

   always @(posedge clk) begin
      if (!reset && load)
         q.push_back('{k + 1, hex_in, dp_in, en_in, blink_in, bright_in, lz_blank});
   end

   always @(posedge reset) q.delete();

   function automatic int act_edge(input int e);
      return ((e + FRAME - 1) / FRAME) * FRAME;
   endfunction

   // Expected {an, sseg, frame_tick, busy} after kk edges since reset release.
   function automatic logic [12:0] model_out(input int kk);
      int s, slot, dig, fr;
      logic ph, busy_m, shown, lead;
      logic [3:0] v;
      logic [2:0] an_m;
      logic [7:0] seg_m;
      ld_t d;
      if (kk == 0) return {3'b111, 8'hFF, 1'b0, 1'b0};
      s    = kk - 1;
      slot = s % SLOT;
      dig  = (s / SLOT) % DIGITS;
      fr   = s / FRAME;
      ph   = ((fr / (1 << BLINK_LOG2)) % 2) == 1;
      d    = '{default: 0};
      busy_m = 1'b0;
      foreach (q[j]) begin
         if (act_edge(q[j].e) <= s) d = q[j];
         if (q[j].e <= kk && act_edge(q[j].e) > kk) busy_m = 1'b1;
      end
      v     = d.hex[4*dig +: 4];
      shown = d.en[dig];
      if (d.lz && dig > 0 && v == 4'd0) begin
         lead = 1'b1;
         for (int j = dig + 1; j < DIGITS; j++)
            if (d.hex[4*j +: 4] != 4'd0 && d.en[j]) lead = 1'b0;
         if (lead) shown = 1'b0;
      end
      if (d.blink[dig] && ph) shown = 1'b0;
      seg_m = shown ? ~{d.dp[dig], GLYPH[v]} : 8'hFF;
      an_m  = (shown && slot < int'(d.bright)) ? ~(3'b001 << dig) : 3'b111;
      return {an_m, seg_m, (kk % FRAME) == 0, busy_m};
   endfunction

   task automatic stage(input logic [11:0] h, input logic [2:0] dp, input logic [2:0] en,
                        input logic [2:0] bl, input logic [3:0] br, input logic lz);
      hex_in = h; dp_in = dp; en_in = en; blink_in = bl; bright_in = br; lz_blank = lz;
      load = 1'b1;
   endtask

   task automatic stage_rand();
      logic [31:0] r;
      r = $urandom;
      stage(r[11:0], r[14:12], r[17:15] | 3'b001, r[20:18], r[24:21], r[25]);
   endtask

   task automatic test_reset();
      int cnt;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({an, sseg} !== 11'h7FF) begin
         failures++;
         $display("FAIL reset_pins dut=%h required=7ff", {an, sseg});
      end
      tests_run++;
      if ({frame_tick, busy} !== 2'b00) begin
         failures++;
         $display("FAIL reset_flags dut=%b required=00", {frame_tick, busy});
      end
      reset = 1'b0;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!frame_tick && cnt < 200);
      tests_run++;
      if (cnt != FRAME) begin
         failures++;
         $display("FAIL first_tick cycles=%0d required=%0d", cnt, FRAME);
      end
   endtask

   task automatic test_scan();
      logic [10:0] exp_d [3] = '{{3'b110, 8'h86}, {3'b101, 8'h88}, {3'b011, 8'hA4}};
      for (int i = 0; i < 4 * FRAME; i++) begin
         @(negedge clk);
         tests_run++;
         if (obs !== model_out(k)) begin
            failures++;
            $display("FAIL scan k=%0d dut=%h model=%h", k, obs, model_out(k));
         end
         if (k > 2 * FRAME && (k - 1) % SLOT == 0) begin
            tests_run++;
            if ({an, sseg} !== exp_d[((k - 1) / SLOT) % DIGITS]) begin
               failures++;
               $display("FAIL scan_glyph k=%0d dut=%h required=%h", k, {an, sseg},
                        exp_d[((k - 1) / SLOT) % DIGITS]);
            end
         end
         load = 1'b0;
         if (i == 2) stage(12'h5A3, 3'b000, 3'b111, 3'b000, 4'd15, 1'b0);
      end
   endtask

   task automatic test_midframe();
      int mid_k = -1, co_k = -1;
      for (int i = 0; i < 4 * FRAME; i++) begin
         @(negedge clk);
         tests_run++;
         if (obs !== model_out(k)) begin
            failures++;
            $display("FAIL midframe k=%0d dut=%h model=%h", k, obs, model_out(k));
         end
         if (mid_k >= 0 && k == mid_k + 1) begin
            tests_run++;
            if (busy !== 1'b1) begin
               failures++;
               $display("FAIL mid_busy dut=%b required=1", busy);
            end
         end
         if (co_k >= 0 && k == co_k + 1) begin
            tests_run++;
            if (busy !== 1'b0) begin
               failures++;
               $display("FAIL coincident_busy dut=%b required=0", busy);
            end
         end
         load = 1'b0;
         if (mid_k < 0 && k % FRAME == 20) begin
            stage_rand();
            mid_k = k;
         end else if (co_k < 0 && i > 2 * FRAME && k % FRAME == FRAME - 1) begin
            stage_rand();
            co_k = k;
         end
      end
   endtask

   task automatic test_lz();
      for (int i = 0; i < 6 * FRAME; i++) begin
         @(negedge clk);
         tests_run++;
         if (obs !== model_out(k)) begin
            failures++;
            $display("FAIL lz k=%0d dut=%h model=%h", k, obs, model_out(k));
         end
         load = 1'b0;
         if (i == 0) stage(12'h007, 3'b000, 3'b111, 3'b000, 4'd15, 1'b1);
         if (i == 2 * FRAME) stage(12'h000, 3'b111, 3'b111, 3'b000, 4'd15, 1'b1);
         if (i == 4 * FRAME) stage(12'h0F0 & 12'($urandom), 3'b101, 3'b011, 3'b000, 4'd15, 1'b1);
      end
   endtask

   task automatic test_pwm();
      int win_a, win_b, cnt_a = 0, cnt_b = 0;
      win_a = k / FRAME + 2;
      win_b = k / FRAME + 5;
      for (int i = 0; i < 7 * FRAME; i++) begin
         @(negedge clk);
         tests_run++;
         if (obs !== model_out(k)) begin
            failures++;
            $display("FAIL pwm k=%0d dut=%h model=%h", k, obs, model_out(k));
         end
         if ((k - 1) / FRAME == win_a && an != 3'b111) cnt_a++;
         if ((k - 1) / FRAME == win_b && an != 3'b111) cnt_b++;
         load = 1'b0;
         if (i == 0) stage(12'($urandom), 3'($urandom), 3'b111, 3'b000, 4'd4, 1'b0);
         if (i == 3 * FRAME) stage(12'($urandom), 3'b111, 3'b111, 3'b000, 4'd0, 1'b0);
      end
      tests_run++;
      if (cnt_a != 4 * DIGITS) begin
         failures++;
         $display("FAIL pwm_duty4 on_cycles=%0d required=%0d", cnt_a, 4 * DIGITS);
      end
      tests_run++;
      if (cnt_b != 0) begin
         failures++;
         $display("FAIL pwm_duty0 on_cycles=%0d required=0", cnt_b);
      end
   endtask

   task automatic test_blink();
      for (int i = 0; i < 8 * FRAME; i++) begin
         @(negedge clk);
         tests_run++;
         if (obs !== model_out(k)) begin
            failures++;
            $display("FAIL blink k=%0d dut=%h model=%h", k, obs, model_out(k));
         end
         load = 1'b0;
         if (i == 0) stage(12'($urandom), 3'b010, 3'b111, 3'b010, 4'd15, 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6 * FRAME; i++) begin
         @(negedge clk);
         tests_run++;
         if (obs !== model_out(k)) begin
            failures++;
            $display("FAIL back_to_back k=%0d dut=%h model=%h", k, obs, model_out(k));
         end
         load = 1'b0;
         if (i >= 10 && i <= 12) stage_rand();
         else if (i > 2 * FRAME && $urandom_range(0, 40) == 0) stage_rand();
      end
   endtask

   task automatic test_reset_midframe();
      for (int n = 0; n < 200 && k % FRAME != 30; n++) @(negedge clk);
      load = 1'b0;
      stage(12'($urandom), 3'b111, 3'b111, 3'b000, 4'd15, 1'b0);
      @(negedge clk);
      load = 1'b0;
      for (int n = 0; n < 200 && k % FRAME != 40; n++) @(negedge clk);
      tests_run++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_busy dut=%b required=1", busy);
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if (obs !== {3'b111, 8'hFF, 2'b00}) begin
         failures++;
         $display("FAIL async_reset dut=%h required=%h", obs, {3'b111, 8'hFF, 2'b00});
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         tests_run++;
         if (obs !== model_out(k)) begin
            failures++;
            $display("FAIL post_reset k=%0d dut=%h model=%h", k, obs, model_out(k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_midframe();
      test_lz();
      test_pwm();
      test_blink();
      test_back_to_back();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/sseg_scan_mux.md
# sseg_scan_mux

Parametrised time-multiplexed seven-segment display driver for DIGITS common-anode digits, with per-digit enable, decimal point and blink, global 4-bit PWM brightness, and optional leading-zero blanking. Display data is written through a load-pulse shadow register, so every update takes effect atomically at a frame boundary. It sits between the application/BCD datapath and the board's anode and segment pins and is the general replacement for the fixed 3-digit hex multiplexer.

## Interface
- DIGITS, 3: number of multiplexed digits, 2..8.
- SCAN_LOG2, 12: log2 of clock cycles per digit slot. 12 MHz / (4096·3) ≈ 977 Hz frame rate.
- BLINK_LOG2, 6: log2 of frames per blink half-period.
- ACTIVE_LOW, 1: 1 means anodes and segments are active-low at the pins.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- load  in  1  single-cycle strobe; captures all *_in inputs.
- hex_in  in  4·DIGITS  digit values; digit i is [4i+3:4i]; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- en_in  in  DIGITS  digit enable; 0 = fully blank.
- blink_in  in  DIGITS  1 = digit blinks.
- bright_in  in  4  brightness 0..15.
- lz_blank  in  1  1 = blank leading zeros.
- an  out  DIGITS  anode select, one-hot (polarity per ACTIVE_LOW).
- sseg  out  8  {dp, a, b, c, d, e, f, g}; bit 7 = dp, bit 6 = a, bit 0 = g.
- frame_tick  out  1  one-cycle pulse at each frame wrap.
- busy  out  1  loaded data pending, not yet displayed.

## Operation
- slot_cnt: a SCAN_LOG2-bit free-running counter. When it wraps to 0, idx advances; idx runs 0..DIGITS-1 and then wraps to 0.
- A frame wrap is the cycle in which both slot_cnt and idx wrap. frame_tick is registered and is high in the following cycle.
- Shadow register:
  - load captures the inputs into the pending registers and sets busy.
  - At a frame wrap with busy=1, pending is copied to active and busy clears.
  - If load and a frame wrap occur in the same cycle, the inputs go directly to active and busy stays 0.
  - A second load while busy overwrites pending; the last load wins.
- Leading-zero blanking, when enabled in the active registers:
  - Scan from digit DIGITS-1 downward.
  - A digit is blanked while its value is 0 and every higher digit is either 0 or disabled.
  - Digit 0 is never blanked by this rule.
  - dp is blanked together with its digit.
- Blink: blink_cnt counts frames. blink_ph toggles every 2^BLINK_LOG2 frames. While blink_ph=1, every digit with blink=1 is blanked.
- PWM: the current anode is asserted only while slot_cnt[SCAN_LOG2-1 -: 4] < bright.
  - bright=0 keeps all anodes off.
  - bright=15 gives a 15/16 duty cycle.
  - Segments still show the current digit whenever the digit is not blanked.
- Segment decode uses the standard hex glyphs 0–F.
- Blanked digit: all segments and dp off, and its anode is deasserted.
- ACTIVE_LOW=1 inverts both an and sseg at the output registers.

## Timing
- an, sseg and frame_tick are registered: one cycle of latency from the slot_cnt/idx state.
- Output reset values, with ACTIVE_LOW=1:
  - an = all 1s.
  - sseg = 8'hFF.
  - frame_tick = 0; busy = 0.
- Internal reset values: slot_cnt, idx, blink_cnt and blink_ph = 0; active and pending registers = 0, so all digits are disabled.
- After reset, digit 0 is scanned first. The first frame_tick appears DIGITS·2^SCAN_LOG2 cycles after reset is released.
- Loaded data becomes visible in the first slot after the next frame wrap. The worst case is one full frame plus 1 cycle.
- Reset asserted mid-frame returns all outputs to their reset values immediately (asynchronous) and drops any pending load.

## Structure
- Package sseg_pkg holds:
  - function hex_to_seg (4 bits → 7-bit active-high a..g);
  - constant SEG_BLANK;
  - brightness width constant BRIGHT_W = 4.
- Sub-module sseg_lz_mask: combinational, takes the DIGITS values and enables and produces the DIGITS-bit leading-zero blank mask.
- The top level holds the counters, shadow registers, blink logic, PWM compare and output registers.

## Test plan
All scenarios use DIGITS=3, SCAN_LOG2=4, BLINK_LOG2=1.
- Reset, then load hex=12'h5A3, en=3'b111, bright=15, no blink → the scan shows digit 0 = 3, digit 1 = A, digit 2 = 5. an cycles 110, 101, 011 every 16 cycles; sseg = ~{0, glyph}. busy clears at the first frame wrap.
- Load at a mid-frame cycle → busy=1 and the old data is shown until the frame_tick boundary; the new data appears in the slot after it. A load coincident with the wrap → busy never rises.
- lz_blank=1, hex=12'h007, en=111 → digits 2 and 1 are blanked (anode off, sseg=FF) and digit 0 shows 7. With hex=12'h000, digit 0 shows 0.
- bright=4 → each slot asserts its anode for exactly 4 of 16 cycles (slot_cnt 0–3). bright=0 → an stays 111 throughout.
- blink=3'b010 → digit 1 is shown for 2 frames and blanked for 2 frames, alternating; digits 0 and 2 are unaffected.
- Assert reset during slot 2 with busy=1 → outputs go to an=111, sseg=FF immediately; after release, busy=0, the scan restarts at digit 0 and all digits are blank until a new load.
